// File: rtl/gmii_rx_mac.sv
// gmii_rx_mac: GMII receive front end; strips preamble/SFD/FCS, checks error/length/CRC and streams payload bytes.
module gmii_rx_mac #(
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1518
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rxdv,
    input  logic        gmii_rxer,
    output logic [7:0]  axis_o_tdata,
    output logic        axis_o_tvalid,
    output logic        axis_o_tlast,
    output logic        axis_o_tuser,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_bad
);
    localparam logic [15:0] MIN_L   = 16'(MIN_FRAME_BYTES);
    localparam logic [15:0] MAX_L   = 16'(MAX_FRAME_BYTES);
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t          state, state_nx;
    logic            rxdv_q, err;
    logic [15:0]     cnt;
    logic [31:0]     crc;
    logic [4:0][7:0] line;
    logic            start, take, fin, full, bad;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (gmii_rxdv) state_nx = (!rxdv_q && gmii_rxd == 8'h55) ? PREAMBLE : DROP;
            PREAMBLE: state_nx = !gmii_rxdv ? IDLE :
                                 gmii_rxer ? DROP :
                                 gmii_rxd == 8'h55 ? PREAMBLE :
                                 gmii_rxd == 8'hD5 ? DATA : DROP;
            default:  if (!gmii_rxdv) state_nx = IDLE;
        endcase
        start = (state == PREAMBLE) && (state_nx == DATA);
        take  = (state == DATA) && gmii_rxdv;
        fin   = (state == DATA) && !gmii_rxdv;
        // the last four bytes are FCS, so a byte is only released once five are held
        full  = cnt >= 16'd5;
        bad   = err || crc != RESIDUE || cnt < MIN_L || cnt > MAX_L;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            rxdv_q        <= 1'b1;
            err           <= 1'b0;
            cnt           <= '0;
            crc           <= '1;
            line          <= '0;
            axis_o_tdata  <= '0;
            axis_o_tvalid <= 1'b0;
            axis_o_tlast  <= 1'b0;
            axis_o_tuser  <= 1'b0;
            frames_ok     <= '0;
            frames_bad    <= '0;
        end else begin
            state         <= state_nx;
            rxdv_q        <= gmii_rxdv;
            axis_o_tvalid <= 1'b0;
            axis_o_tlast  <= 1'b0;
            axis_o_tuser  <= 1'b0;
            if (start) begin
                cnt <= '0;
                crc <= '1;
                err <= 1'b0;
            end
            if (take) begin
                line <= {line[3:0], gmii_rxd};
                crc  <= crc_byte(crc, gmii_rxd);
                cnt  <= (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
                err  <= err | gmii_rxer;
                if (full) begin
                    axis_o_tvalid <= 1'b1;
                    axis_o_tdata  <= line[4];
                end
            end
            if (fin) begin
                if (full) begin
                    axis_o_tvalid <= 1'b1;
                    axis_o_tlast  <= 1'b1;
                    axis_o_tuser  <= bad;
                    axis_o_tdata  <= line[4];
                end
                if (!full || bad) frames_bad <= frames_bad + 16'd1;
                else frames_ok <= frames_ok + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_gmii_rx_mac.sv
// tb_gmii_rx_mac: directed scenarios for the GMII receive front end with hand-derived beat streams.
module tb_gmii_rx_mac;
    logic        clk = 1'b0, aresetn = 1'b0;
    logic [7:0]  gmii_rxd = '0;
    logic        gmii_rxdv = 1'b0, gmii_rxer = 1'b0;
    logic [7:0]  axis_o_tdata;
    logic        axis_o_tvalid, axis_o_tlast, axis_o_tuser;
    logic [15:0] frames_ok, frames_bad;

    int          total = 0, nbad = 0, cyc = 0, start_cyc = 0;
    logic [9:0]  beats[$];
    int          beat_cyc[$];
    logic [7:0]  pl[$];

    gmii_rx_mac dut (
        .clk(clk), .aresetn(aresetn), .gmii_rxd(gmii_rxd), .gmii_rxdv(gmii_rxdv), .gmii_rxer(gmii_rxer),
        .axis_o_tdata(axis_o_tdata), .axis_o_tvalid(axis_o_tvalid), .axis_o_tlast(axis_o_tlast),
        .axis_o_tuser(axis_o_tuser), .frames_ok(frames_ok), .frames_bad(frames_bad)
    );

    always #4 clk = ~clk;

    // beat capture: {tuser, tlast, tdata} sampled 1 ns after each rising edge
    always @(posedge clk) begin
        cyc++;
        #1;
        if (axis_o_tvalid) begin
            beats.push_back({axis_o_tuser, axis_o_tlast, axis_o_tdata});
            beat_cyc.push_back(cyc);
        end
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) r = (r >> 1) ^ ((r[0] ^ d[b]) ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction

    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        @(negedge clk);
        gmii_rxdv = dv;
        gmii_rxd  = d;
        gmii_rxer = er;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic mkpl(input int n, input int base);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'(base + i));
    endtask

    task automatic send(input bit add_fcs, input logic [7:0] flip, input int er_at, input int gap);
        logic [31:0] c;
        logic [7:0]  fr[$];
        fr = pl;
        if (add_fcs) begin
            c = 32'hFFFFFFFF;
            foreach (pl[i]) c = crc_upd(c, pl[i]);
            c = ~c;
            for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
            fr[fr.size()-1] = fr[fr.size()-1] ^ flip;
        end
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        foreach (fr[i]) begin
            drive(1'b1, fr[i], i == er_at);
            if (i == 0) start_cyc = cyc + 1;
        end
        idle(gap);
    endtask

    task automatic test_reset;
        #3;
        total++; if (axis_o_tvalid !== 1'b0) begin nbad++; $display("FAIL reset_tvalid got=%b want=0", axis_o_tvalid); end
        total++; if (axis_o_tlast !== 1'b0) begin nbad++; $display("FAIL reset_tlast got=%b want=0", axis_o_tlast); end
        total++; if (axis_o_tuser !== 1'b0) begin nbad++; $display("FAIL reset_tuser got=%b want=0", axis_o_tuser); end
        total++; if (axis_o_tdata !== 8'h00) begin nbad++; $display("FAIL reset_tdata got=%h want=00", axis_o_tdata); end
        total++; if (frames_ok !== 16'd0) begin nbad++; $display("FAIL reset_ok got=%0d want=0", frames_ok); end
        total++; if (frames_bad !== 16'd0) begin nbad++; $display("FAIL reset_bad got=%0d want=0", frames_bad); end
        @(negedge clk);
        aresetn = 1'b1;
        idle(3);
    endtask

    task automatic test_good;
        logic [9:0] exp;
        beats.delete(); beat_cyc.delete();
        mkpl(60, 0);
        send(1'b1, 8'h00, -1, 1);
        idle(3);
        total++; if (beats.size() != 60) begin nbad++; $display("FAIL good_count got=%0d want=60", beats.size()); end
        for (int i = 0; i < beats.size(); i++) begin
            exp = {1'b0, i == 59, 8'(i)};
            total++; if (beats[i] !== exp) begin nbad++; $display("FAIL good_beat%0d got=%h want=%h", i, beats[i], exp); end
        end
        if (beat_cyc.size() > 0) begin
            total++; if (beat_cyc[0] - start_cyc != 5) begin nbad++; $display("FAIL good_latency got=%0d want=5", beat_cyc[0] - start_cyc); end
        end
        total++; if (frames_ok !== 16'd1) begin nbad++; $display("FAIL good_ok got=%0d want=1", frames_ok); end
        total++; if (frames_bad !== 16'd0) begin nbad++; $display("FAIL good_bad got=%0d want=0", frames_bad); end
    endtask

    task automatic test_bad_fcs;
        logic [9:0] exp;
        beats.delete();
        mkpl(60, 0);
        send(1'b1, 8'h01, -1, 1);
        idle(3);
        total++; if (beats.size() != 60) begin nbad++; $display("FAIL fcs_count got=%0d want=60", beats.size()); end
        for (int i = 0; i < beats.size(); i++) begin
            exp = {i == 59, i == 59, 8'(i)};
            total++; if (beats[i] !== exp) begin nbad++; $display("FAIL fcs_beat%0d got=%h want=%h", i, beats[i], exp); end
        end
        total++; if (frames_bad !== 16'd1) begin nbad++; $display("FAIL fcs_bad got=%0d want=1", frames_bad); end
        total++; if (frames_ok !== 16'd1) begin nbad++; $display("FAIL fcs_ok got=%0d want=1", frames_ok); end
    endtask

    task automatic test_rxer;
        logic [9:0] exp;
        beats.delete();
        mkpl(60, 0);
        send(1'b1, 8'h00, 30, 1);
        idle(3);
        total++; if (beats.size() != 60) begin nbad++; $display("FAIL rxer_count got=%0d want=60", beats.size()); end
        for (int i = 0; i < beats.size(); i++) begin
            exp = {i == 59, i == 59, 8'(i)};
            total++; if (beats[i] !== exp) begin nbad++; $display("FAIL rxer_beat%0d got=%h want=%h", i, beats[i], exp); end
        end
        total++; if (frames_bad !== 16'd2) begin nbad++; $display("FAIL rxer_bad got=%0d want=2", frames_bad); end
    endtask

    task automatic test_runt;
        logic [9:0] exp;
        beats.delete();
        mkpl(16, 8'h40);
        send(1'b1, 8'h00, -1, 1);
        idle(3);
        total++; if (beats.size() != 16) begin nbad++; $display("FAIL runt_count got=%0d want=16", beats.size()); end
        for (int i = 0; i < beats.size(); i++) begin
            exp = {i == 15, i == 15, 8'(64 + i)};
            total++; if (beats[i] !== exp) begin nbad++; $display("FAIL runt_beat%0d got=%h want=%h", i, beats[i], exp); end
        end
        total++; if (frames_bad !== 16'd3) begin nbad++; $display("FAIL runt_bad got=%0d want=3", frames_bad); end
        beats.delete();
        mkpl(3, 8'hA0);
        send(1'b0, 8'h00, -1, 1);
        idle(3);
        total++; if (beats.size() != 0) begin nbad++; $display("FAIL tiny_count got=%0d want=0", beats.size()); end
        total++; if (frames_bad !== 16'd4) begin nbad++; $display("FAIL tiny_bad got=%0d want=4", frames_bad); end
        total++; if (frames_ok !== 16'd1) begin nbad++; $display("FAIL tiny_ok got=%0d want=1", frames_ok); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] exp;
        beats.delete();
        mkpl(60, 0);
        send(1'b1, 8'h00, -1, 1);
        mkpl(60, 8'h80);
        send(1'b1, 8'h00, -1, 1);
        idle(3);
        total++; if (beats.size() != 120) begin nbad++; $display("FAIL b2b_count got=%0d want=120", beats.size()); end
        for (int i = 0; i < beats.size(); i++) begin
            exp = {1'b0, i == 59 || i == 119, 8'(i < 60 ? i : 128 + i - 60)};
            total++; if (beats[i] !== exp) begin nbad++; $display("FAIL b2b_beat%0d got=%h want=%h", i, beats[i], exp); end
        end
        total++; if (frames_ok !== 16'd3) begin nbad++; $display("FAIL b2b_ok got=%0d want=3", frames_ok); end
        total++; if (frames_bad !== 16'd4) begin nbad++; $display("FAIL b2b_bad got=%0d want=4", frames_bad); end
    endtask

    task automatic test_reset_mid;
        logic [9:0] exp;
        beats.delete();
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 8'(i), 1'b0);
        @(negedge clk);
        gmii_rxd = 8'h55;
        aresetn  = 1'b0;
        #1;
        total++; if (axis_o_tvalid !== 1'b0) begin nbad++; $display("FAIL mid_tvalid got=%b want=0", axis_o_tvalid); end
        total++; if (frames_ok !== 16'd0 || frames_bad !== 16'd0) begin nbad++; $display("FAIL mid_counters got=%0d/%0d want=0/0", frames_ok, frames_bad); end
        total++; if (beats.size() != 5) begin nbad++; $display("FAIL mid_pre_count got=%0d want=5", beats.size()); end
        for (int i = 0; i < beats.size(); i++) begin
            exp = {2'b00, 8'(i)};
            total++; if (beats[i] !== exp) begin nbad++; $display("FAIL mid_pre_beat%0d got=%h want=%h", i, beats[i], exp); end
        end
        beats.delete();
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h55, 1'b0);
        @(negedge clk);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 12; i++) drive(1'b1, 8'(i + 1), 1'b0);
        idle(3);
        total++; if (beats.size() != 0) begin nbad++; $display("FAIL mid_drop_count got=%0d want=0", beats.size()); end
        total++; if (frames_ok !== 16'd0 || frames_bad !== 16'd0) begin nbad++; $display("FAIL mid_drop_counters got=%0d/%0d want=0/0", frames_ok, frames_bad); end
        mkpl(60, 8'h10);
        send(1'b1, 8'h00, -1, 1);
        idle(3);
        total++; if (beats.size() != 60) begin nbad++; $display("FAIL mid_next_count got=%0d want=60", beats.size()); end
        for (int i = 0; i < beats.size(); i++) begin
            exp = {1'b0, i == 59, 8'(16 + i)};
            total++; if (beats[i] !== exp) begin nbad++; $display("FAIL mid_next_beat%0d got=%h want=%h", i, beats[i], exp); end
        end
        total++; if (frames_ok !== 16'd1) begin nbad++; $display("FAIL mid_next_ok got=%0d want=1", frames_ok); end
    endtask

    initial begin
        test_reset;
        test_good;
        test_bad_fcs;
        test_rxer;
        test_runt;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end
endmodule
